// File: rtl/axi_perf_pkg.sv
// ============================================================================
// Module      : axi_perf_pkg
// Description : Shared AXI encodings, traffic generator state enum and the
//               data pattern function used by the generator and its bench.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_perf_pkg;

  // AXI response encodings
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // AXI burst type encoding
  localparam logic [1:0] BURST_INCR = 2'b01;

  // Widest data bus the pattern function covers
  localparam int PATTERN_MAX_W = 64;

  // Traffic generator phases
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  // Beat pattern: zero-extended beat address XOR the seed replicated to
  // 64 bits; callers keep the low data-width bits.
  function automatic logic [PATTERN_MAX_W-1:0] perf_pattern(
    input logic [PATTERN_MAX_W-1:0] addr,
    input logic [15:0]              seed
  );
    return addr ^ {4{seed}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_perf_traffic_gen_if.sv
// ============================================================================
// Module      : axi_perf_traffic_gen_if
// Description : AXI4 AW/W/B/AR/R channel bundle with manager and subordinate
//               views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_perf_traffic_gen_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int ID_W   = 4
) ();

  // Write address channel
  logic              awvalid;
  logic              awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  // Write data channel
  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  // Write response channel
  logic            bvalid;
  logic            bready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;

  // Read address channel
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  // Read data channel
  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );

endinterface

`default_nettype wire

// File: rtl/axi_perf_traffic_gen.sv
// ============================================================================
// Module      : axi_perf_traffic_gen
// Description : AXI4 manager that writes NUM_BURSTS INCR bursts of an
//               address-derived pattern, reads them back, checks every beat
//               and reports an error count and the run length in cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_perf_traffic_gen
  import axi_perf_pkg::*;
#(
  parameter int                        AXI_ADDR_WIDTH = 20,
  parameter int                        AXI_DATA_WIDTH = 16,
  parameter int                        AXI_ID_WIDTH   = 4,
  parameter logic [AXI_ID_WIDTH-1:0]   AXI_ID         = '0,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                        BURST_LEN      = 8,
  parameter int                        NUM_BURSTS     = 16,
  parameter logic [15:0]               SEED           = 16'hA5C3
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               start,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             err_cnt,
  output logic [31:0]             cycle_cnt,
  axi_perf_traffic_gen_if.master  m_axi
);

  localparam int BYTES   = AXI_DATA_WIDTH / 8;
  localparam int BURST_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

  localparam logic [7:0]                LAST_BEAT    = 8'(BURST_LEN - 1);
  localparam logic [BURST_W-1:0]        LAST_BURST   = BURST_W'(NUM_BURSTS - 1);
  localparam logic [2:0]                AX_SIZE      = 3'($clog2(BYTES));
  localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_STRIDE  = AXI_ADDR_WIDTH'(BYTES);
  localparam logic [AXI_ADDR_WIDTH-1:0] BURST_STRIDE = AXI_ADDR_WIDTH'(BURST_LEN * BYTES);

  // Expected data for one beat address, truncated to the bus width
  function automatic logic [AXI_DATA_WIDTH-1:0] beat_pattern(
    input logic [AXI_ADDR_WIDTH-1:0] a
  );
    logic [PATTERN_MAX_W-1:0] full;
    full = perf_pattern(PATTERN_MAX_W'(a), SEED);
    return full[AXI_DATA_WIDTH-1:0];
  endfunction

  state_e                      state_q,   state_d;
  logic [BURST_W-1:0]          burst_q,   burst_d;
  logic [7:0]                  beat_q,    beat_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q,    addr_d;
  logic                        awvalid_q, awvalid_d;
  logic                        wvalid_q,  wvalid_d;
  logic                        wlast_q,   wlast_d;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q,   wdata_d;
  logic                        bready_q,  bready_d;
  logic                        arvalid_q, arvalid_d;
  logic                        rready_q,  rready_d;
  logic                        busy_q,    busy_d;
  logic                        done_q,    done_d;
  logic [15:0]                 err_q,     err_d;
  logic [31:0]                 cyc_q,     cyc_d;

  logic                        beat_err;
  logic [AXI_ADDR_WIDTH-1:0]   beat_addr;

  // Address of the beat the counters currently point at
  assign beat_addr = addr_q + (AXI_ADDR_WIDTH'(beat_q) << AX_SIZE);

  // Next-state, channel control and check logic for the whole run
  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wlast_d   = wlast_q;
    wdata_d   = wdata_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    cyc_d     = cyc_q;
    beat_err  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_AW;
          burst_d   = '0;
          beat_d    = '0;
          addr_d    = BASE_ADDR;
          awvalid_d = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = '0;
          cyc_d     = '0;
        end
      end

      ST_AW: begin
        if (awvalid_q && m_axi.awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wdata_d   = beat_pattern(addr_q);
          wlast_d   = (LAST_BEAT == 8'd0);
          beat_d    = '0;
          state_d   = ST_W;
        end
      end

      ST_W: begin
        if (wvalid_q && m_axi.wready) begin
          if (beat_q == LAST_BEAT) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
            state_d  = ST_B;
          end else begin
            // Preload the following beat so W can stream back-to-back
            beat_d  = beat_q + 8'd1;
            wdata_d = beat_pattern(beat_addr + BEAT_STRIDE);
            wlast_d = ((beat_q + 8'd1) == LAST_BEAT);
          end
        end
      end

      ST_B: begin
        if (bready_q && m_axi.bvalid) begin
          bready_d = 1'b0;
          beat_err = (m_axi.bresp != OKAY) || (m_axi.bid != AXI_ID);
          beat_d   = '0;
          if (burst_q == LAST_BURST) begin
            // Write phase finished: restart counters for the read phase
            burst_d   = '0;
            addr_d    = BASE_ADDR;
            arvalid_d = 1'b1;
            state_d   = ST_AR;
          end else begin
            burst_d   = burst_q + 1'b1;
            addr_d    = addr_q + BURST_STRIDE;
            awvalid_d = 1'b1;
            state_d   = ST_AW;
          end
        end
      end

      ST_AR: begin
        if (arvalid_q && m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          beat_d    = '0;
          state_d   = ST_R;
        end
      end

      ST_R: begin
        if (rready_q && m_axi.rvalid) begin
          // Any combination of faults on one beat counts once
          beat_err = (m_axi.rresp != OKAY) ||
                     (m_axi.rid != AXI_ID) ||
                     (m_axi.rdata != beat_pattern(beat_addr)) ||
                     (m_axi.rlast != (beat_q == LAST_BEAT));
          // The beat count, not rlast, decides where a burst ends
          if (beat_q == LAST_BEAT) begin
            rready_d = 1'b0;
            beat_d   = '0;
            if (burst_q == LAST_BURST) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              burst_d   = burst_q + 1'b1;
              addr_d    = addr_q + BURST_STRIDE;
              arvalid_d = 1'b1;
              state_d   = ST_AR;
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // busy is low in IDLE/DONE, so this never overrides the clear on start
    if (busy_q) begin
      cyc_d = cyc_q + 32'd1;
    end

    if (beat_err && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      burst_q   <= '0;
      beat_q    <= '0;
      addr_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      wdata_q   <= '0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= '0;
      cyc_q     <= '0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      wdata_q   <= wdata_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cyc_q     <= cyc_d;
    end
  end

  // Bus outputs come straight from flops or constants
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.awid    = AXI_ID;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = LAST_BEAT;
  assign m_axi.awsize  = AX_SIZE;
  assign m_axi.awburst = BURST_INCR;

  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = wlast_q;

  assign m_axi.bready  = bready_q;

  assign m_axi.arvalid = arvalid_q;
  assign m_axi.arid    = AXI_ID;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = LAST_BEAT;
  assign m_axi.arsize  = AX_SIZE;
  assign m_axi.arburst = BURST_INCR;

  assign m_axi.rready  = rready_q;

  assign busy      = busy_q;
  assign done      = done_q;
  assign err_cnt   = err_q;
  assign cycle_cnt = cyc_q;

endmodule

`default_nettype wire
